// File: rtl/btb_predictor.sv
// btb_predictor: fully associative branch target buffer for the fetch stage.
// A lookup of fetch_pc returns hit, direction, target and entry index one cycle
// later. The execute stage trains it with one resolved branch per cycle.
// Each entry has a 2-bit saturating counter for the direction prediction.
// Optional feature: define BTB_INV_EN to add the btb_inv flush input.
module btb_predictor #(
   parameter int         BTB_ENTRIES = 32,
   parameter int         IDX_W       = 5,
   parameter logic [1:0] CNT_INIT    = 2'b10
) (
   input  logic             clk,
   input  logic             reset,
`ifdef BTB_INV_EN
   input  logic             btb_inv,
`endif
   input  logic [31:0]      fetch_pc,
   input  logic             fetch_en,
   output logic             btb_en,
   output logic             btb_taken,
   output logic [31:0]      btb_ret_pc,
   output logic [IDX_W-1:0] btb_index,
   input  logic             upd_valid,
   input  logic [31:0]      upd_pc,
   input  logic [31:0]      upd_target,
   input  logic             upd_taken,
   input  logic             upd_hit,
   input  logic [IDX_W-1:0] upd_index
);

   logic [BTB_ENTRIES-1:0] valid;
   logic [29:0]            tag    [BTB_ENTRIES];
   logic [29:0]            target [BTB_ENTRIES];
   logic [1:0]             cnt    [BTB_ENTRIES];
   logic [IDX_W-1:0]       rr_ptr;

   logic             lk_hit;
   logic [IDX_W-1:0] lk_idx;
   logic             um_hit;
   logic [IDX_W-1:0] um_idx;
   logic             free_any;
   logic [IDX_W-1:0] free_idx;
   logic             upd_go;
   logic             do_hit;
   logic             do_alloc;
   logic [IDX_W-1:0] hit_idx;
   logic [IDX_W-1:0] alloc_idx;

   // Byte-offset bits of the addresses never take part in matching or storage.
   logic unused_bits;
   assign unused_bits = ^{fetch_pc[1:0], upd_pc[1:0], upd_target[1:0]};

   function automatic logic [1:0] sat_cnt(input logic [1:0] c, input logic up);
      logic [1:0] r;
      r = c;
      if (up && c != 2'b11)
         r = c + 2'd1;
      else if (!up && c != 2'b00)
         r = c - 2'd1;
      return r;
   endfunction

   // Parallel tag compare for lookup, training match and free-slot search;
   // descending loops make the lowest matching index win.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      lk_hit   = 1'b0;
      lk_idx   = '0;
      um_hit   = 1'b0;
      um_idx   = '0;
      free_any = 1'b0;
      free_idx = '0;
      for (int i = BTB_ENTRIES - 1; i >= 0; i--) begin
         if (valid[i] && tag[i] == fetch_pc[31:2]) begin
            lk_hit = 1'b1;
            lk_idx = IDX_W'(i);
         end
         if (valid[i] && tag[i] == upd_pc[31:2]) begin
            um_hit = 1'b1;
            um_idx = IDX_W'(i);
         end
         if (!valid[i]) begin
            free_any = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end

   // Training decode: a late-allocated branch that reports a miss but already
   // has an entry is treated as a hit, so no duplicate tag is ever created.
   always_comb begin
`ifdef BTB_INV_EN
      upd_go = upd_valid && !reset && !btb_inv;
`else
      upd_go = upd_valid && !reset;
`endif
      do_hit    = upd_go && (upd_hit || um_hit);
      hit_idx   = upd_hit ? upd_index : um_idx;
      do_alloc  = upd_go && !upd_hit && !um_hit && upd_taken;
      alloc_idx = free_any ? free_idx : rr_ptr;
   end

   // Registered lookup result; holds while fetch_en is low so a stalled IF
   // stage can re-sample it.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (reset) begin
         btb_en     <= 1'b0;
         btb_taken  <= 1'b0;
         btb_ret_pc <= '0;
         btb_index  <= '0;
      end else if (fetch_en) begin
         btb_en     <= lk_hit;
         btb_taken  <= lk_hit & cnt[lk_idx][1];
         btb_ret_pc <= lk_hit ? {target[lk_idx], 2'b00} : 32'h0;
         btb_index  <= lk_idx;
      end
   end

   // Valid bits and round-robin replacement pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid  <= '0;
         rr_ptr <= '0;
`ifdef BTB_INV_EN
      end else if (btb_inv) begin
         valid  <= '0;
         rr_ptr <= '0;
`endif
      end else if (do_alloc) begin
         valid[alloc_idx] <= 1'b1;
         if (!free_any)
            rr_ptr <= rr_ptr + IDX_W'(1);
      end
   end

   // Entry payload: tag, target and counter writes on allocation or training.
   always_ff @(posedge clk) begin
      // NOTE: payload arrays are not reset; valid gates every use of them.
      if (do_alloc) begin
         tag[alloc_idx]    <= upd_pc[31:2];
         target[alloc_idx] <= upd_target[31:2];
         cnt[alloc_idx]    <= CNT_INIT;
      end else if (do_hit) begin
         cnt[hit_idx] <= sat_cnt(cnt[hit_idx], upd_taken);
         if (upd_taken)
            target[hit_idx] <= upd_target[31:2];
      end
   end

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: lookup expectations are queued when
// fetch_en is driven and compared when the registered result appears.
module tb_btb_predictor;
   localparam int IDX_W = 5;

   logic             clk = 1'b0;
   logic             reset;
`ifdef BTB_INV_EN
   logic             btb_inv;
`endif
   logic [31:0]      fetch_pc;
   logic             fetch_en;
   logic             btb_en;
   logic             btb_taken;
   logic [31:0]      btb_ret_pc;
   logic [IDX_W-1:0] btb_index;
   logic             upd_valid;
   logic [31:0]      upd_pc;
   logic [31:0]      upd_target;
   logic             upd_taken;
   logic             upd_hit;
   logic [IDX_W-1:0] upd_index;

   btb_predictor #(.BTB_ENTRIES(32), .IDX_W(IDX_W), .CNT_INIT(2'b10)) dut (
      .clk        (clk),
      .reset      (reset),
`ifdef BTB_INV_EN
      .btb_inv    (btb_inv),
`endif
      .fetch_pc   (fetch_pc),
      .fetch_en   (fetch_en),
      .btb_en     (btb_en),
      .btb_taken  (btb_taken),
      .btb_ret_pc (btb_ret_pc),
      .btb_index  (btb_index),
      .upd_valid  (upd_valid),
      .upd_pc     (upd_pc),
      .upd_target (upd_target),
      .upd_taken  (upd_taken),
      .upd_hit    (upd_hit),
      .upd_index  (upd_index)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic             en;
      logic             tk;
      logic [31:0]      ret;
      logic [IDX_W-1:0] idx;
   } exp_t;

   exp_t sb[$];
   logic fired;
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // A lookup was accepted at this edge; its result is due at the next negedge.
   always @(posedge clk) fired <= fetch_en && !reset;

   // Scoreboard: pop the oldest expectation and compare against the outputs.
   always @(negedge clk) begin : mon
      exp_t e;
      if (fired === 1'b1) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            check("lk_en",    32'(btb_en),    32'(e.en));
            check("lk_taken", 32'(btb_taken), 32'(e.tk));
            check("lk_ret",   btb_ret_pc,     e.ret);
            check("lk_index", 32'(btb_index), 32'(e.idx));
         end
      end
   end

   task automatic lookup(input logic [31:0] pc, input logic en, input logic tk,
                         input logic [31:0] ret, input logic [IDX_W-1:0] idx);
      fetch_en = 1'b1;
      fetch_pc = pc;
      sb.push_back('{en: en, tk: tk, ret: ret, idx: idx});
   endtask

   task automatic miss(input logic [31:0] pc);
      lookup(pc, 1'b0, 1'b0, 32'h0, '0);
   endtask

   task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                        input logic hit, input logic [IDX_W-1:0] idx);
      upd_valid  = 1'b1;
      upd_pc     = pc;
      upd_target = tgt;
      upd_taken  = tk;
      upd_hit    = hit;
      upd_index  = idx;
   endtask

   task automatic step();
      @(negedge clk);
      fetch_en  = 1'b0;
      upd_valid = 1'b0;
      upd_hit   = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset     = 1'b0;
      fetch_en  = 1'b0;
      upd_valid = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      reset      = 1'b1;
`ifdef BTB_INV_EN
      btb_inv    = 1'b0;
`endif
      fetch_pc   = '0;
      fetch_en   = 1'b0;
      upd_valid  = 1'b0;
      upd_pc     = '0;
      upd_target = '0;
      upd_taken  = 1'b0;
      upd_hit    = 1'b0;
      upd_index  = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Reset state.
      check("rst_en",    32'(btb_en),    32'd0);
      check("rst_taken", 32'(btb_taken), 32'd0);
      check("rst_ret",   btb_ret_pc,     32'd0);
      check("rst_index", 32'(btb_index), 32'd0);

      // Empty table misses.
      miss(32'h1c00_0000); step();

      // Allocate then hit.
      train(32'h1c00_0010, 32'h1c00_0100, 1'b1, 1'b0, '0); step();
      lookup(32'h1c00_0010, 1'b1, 1'b1, 32'h1c00_0100, 5'd0); step();

      // Counter walk: 10 -> 01 -> 00 -> 00 (saturate low), target kept on not-taken.
      train(32'h1c00_0010, 32'hdead_beec, 1'b0, 1'b1, 5'd0); step();
      lookup(32'h1c00_0010, 1'b1, 1'b0, 32'h1c00_0100, 5'd0); step();
      train(32'h1c00_0010, 32'hdead_beec, 1'b0, 1'b1, 5'd0); step();
      lookup(32'h1c00_0010, 1'b1, 1'b0, 32'h1c00_0100, 5'd0); step();
      train(32'h1c00_0010, 32'hdead_beec, 1'b0, 1'b1, 5'd0); step();
      lookup(32'h1c00_0010, 1'b1, 1'b0, 32'h1c00_0100, 5'd0); step();
      // 00 -> 01 with target rewrite, -> 10, -> 11, -> 11 (saturate high), -> 10.
      train(32'h1c00_0010, 32'h1c00_0200, 1'b1, 1'b1, 5'd0); step();
      lookup(32'h1c00_0010, 1'b1, 1'b0, 32'h1c00_0200, 5'd0); step();
      train(32'h1c00_0010, 32'h1c00_0200, 1'b1, 1'b1, 5'd0); step();
      lookup(32'h1c00_0010, 1'b1, 1'b1, 32'h1c00_0200, 5'd0); step();
      train(32'h1c00_0010, 32'h1c00_0200, 1'b1, 1'b1, 5'd0); step();
      train(32'h1c00_0010, 32'h1c00_0200, 1'b1, 1'b1, 5'd0); step();
      train(32'h1c00_0010, 32'h1c00_0200, 1'b0, 1'b1, 5'd0); step();
      lookup(32'h1c00_0010, 1'b1, 1'b1, 32'h1c00_0200, 5'd0); step();

      // Fill all 32 entries, then the 33rd replaces entry rr_ptr=0.
      do_reset();
      for (int k = 0; k < 33; k++) begin
         train(32'h1c00_0000 + 32'(4 * k), 32'h1c10_0000 + 32'(4 * k), 1'b1, 1'b0, '0);
         step();
      end
      miss(32'h1c00_0000); step();
      lookup(32'h1c00_0080, 1'b1, 1'b1, 32'h1c10_0080, 5'd0);  step();
      lookup(32'h1c00_0004, 1'b1, 1'b1, 32'h1c10_0004, 5'd1);  step();
      lookup(32'h1c00_007c, 1'b1, 1'b1, 32'h1c10_007c, 5'd31); step();
      train(32'h1c00_0084, 32'h1c10_0084, 1'b1, 1'b0, '0); step();
      miss(32'h1c00_0004); step();
      lookup(32'h1c00_0084, 1'b1, 1'b1, 32'h1c10_0084, 5'd1); step();

      // An update presented during reset is dropped.
      reset = 1'b1;
      train(32'h1c00_0090, 32'h1c00_0900, 1'b1, 1'b0, '0);
      step();
      do_reset();
      miss(32'h1c00_0090); step();

      // Same-cycle lookup and allocation: read-before-write.
      miss(32'h1c00_0040);
      train(32'h1c00_0040, 32'h1c00_0400, 1'b1, 1'b0, '0);
      step();
      lookup(32'h1c00_0040, 1'b1, 1'b1, 32'h1c00_0400, 5'd0); step();

      // Outputs hold while fetch_en is low, even with a different fetch_pc.
      fetch_pc = 32'h0000_0000;
      for (int c = 0; c < 5; c++) begin
         step();
         check("hold_en",    32'(btb_en),    32'd1);
         check("hold_ret",   btb_ret_pc,     32'h1c00_0400);
         check("hold_index", 32'(btb_index), 32'd0);
      end

      // Miss-reported update of an existing pc trains that entry, no duplicate.
      train(32'h1c00_0040, 32'h1c00_0303, 1'b1, 1'b0, '0); step();
      lookup(32'h1c00_0043, 1'b1, 1'b1, 32'h1c00_0300, 5'd0); step();
      train(32'h1c00_0050, 32'h1c00_0500, 1'b1, 1'b0, '0); step();
      train(32'h1c00_0050, 32'h1c00_0500, 1'b1, 1'b0, '0); step();
      lookup(32'h1c00_0050, 1'b1, 1'b1, 32'h1c00_0500, 5'd1); step();
      lookup(32'h1c00_0050, 1'b1, 1'b1, 32'h1c00_0500, 5'd1); step();
      train(32'h1c00_0060, 32'h1c00_0600, 1'b1, 1'b0, '0); step();
      lookup(32'h1c00_0060, 1'b1, 1'b1, 32'h1c00_0600, 5'd2); step();

      // A not-taken miss allocates nothing.
      train(32'h1c00_0070, 32'h1c00_0700, 1'b0, 1'b0, '0); step();
      miss(32'h1c00_0070); step();

`ifdef BTB_INV_EN
      // Invalidate: same-cycle lookup sees old contents, same-cycle update is lost.
      btb_inv = 1'b1;
      lookup(32'h1c00_0050, 1'b1, 1'b1, 32'h1c00_0500, 5'd1);
      train(32'h1c00_00a0, 32'h1c00_0a00, 1'b1, 1'b0, '0);
      step();
      btb_inv = 1'b0;
      miss(32'h1c00_0050); step();
      miss(32'h1c00_00a0); step();
      train(32'h1c00_00b0, 32'h1c00_0b00, 1'b1, 1'b0, '0); step();
      lookup(32'h1c00_00b0, 1'b1, 1'b1, 32'h1c00_0b00, 5'd0); step();
`endif

      step();
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
